// File: rtl/pipelined_unsigned_adder.sv
// pipelined_unsigned_adder
//
// Unsigned adder/subtractor of WIDTH bits. The carry chain is cut into
// STAGES chunks of CW = WIDTH/STAGES bits, and one chunk is resolved per
// register stage. Subtraction is done as A + ~B + !CI, and the final carry
// is inverted to give the borrow.
//
// Each stage register holds one operation that is partly finished:
//   word_q : result chunks 0..k already resolved, with the untouched A
//            chunks above k kept in place. The same vector is therefore both
//            the operand skew line and the result deskew line.
//   opb_q  : conditioned B. Only the chunks above k are still needed.
//   cy_q   : carry out of chunk k.
//   sub_q  : operation type, needed at the end to turn carry into borrow.
//   vld_q  : the stage holds a real operation, not a bubble.
//
// A single enable moves every stage forward together. The only
// combinational path through the block is out_ready/out_valid -> in_ready.

module pipelined_unsigned_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             ci,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             co
);

  localparam int CW = WIDTH / STAGES;

  // Global pipeline enable: move forward unless a result is waiting downstream.
  logic en;

  // Stage registers.
  logic             vld_q  [STAGES];
  logic             cy_q   [STAGES];
  logic             sub_q  [STAGES];
  logic [WIDTH-1:0] word_q [STAGES];
  logic [WIDTH-1:0] opb_q  [STAGES];

  // Values presented to each stage's chunk adder.
  logic             vld_in  [STAGES];
  logic             cy_in   [STAGES];
  logic             sub_in  [STAGES];
  logic [WIDTH-1:0] word_in [STAGES];
  logic [WIDTH-1:0] opb_in  [STAGES];

  // Chunk adder results and updated words.
  logic [CW:0]      chunk_sum [STAGES];
  logic [WIDTH-1:0] word_nx   [STAGES];

  assign en        = out_ready | ~out_valid;
  assign in_ready  = en;
  assign out_valid = vld_q[STAGES-1];
  assign sum       = word_q[STAGES-1];
  assign co        = cy_q[STAGES-1] ^ sub_q[STAGES-1];

  // Route inputs to each stage: stage 0 takes the port operands (B and
  // carry-in conditioned for subtract), and each later stage takes the
  // registers of the stage before it.
  always_comb begin
    // NOTE: every element gets a value on every pass, so no latches are
    // inferred for the routing arrays.
    vld_in[0]  = in_valid;
    cy_in[0]   = ci ^ sub;
    sub_in[0]  = sub;
    word_in[0] = a;
    opb_in[0]  = b ^ {WIDTH{sub}};
    for (int k = 1; k < STAGES; k++) begin
      vld_in[k]  = vld_q[k-1];
      cy_in[k]   = cy_q[k-1];
      sub_in[k]  = sub_q[k-1];
      word_in[k] = word_q[k-1];
      opb_in[k]  = opb_q[k-1];
    end
  end

  // Per-stage chunk adder: stage k resolves chunk k and writes it back into
  // the word, replacing the A chunk it used.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      chunk_sum[k] = {1'b0, word_in[k][k*CW +: CW]}
                   + {1'b0, opb_in[k][k*CW +: CW]}
                   + {{CW{1'b0}}, cy_in[k]};
      word_nx[k]             = word_in[k];
      word_nx[k][k*CW +: CW] = chunk_sum[k][CW-1:0];
    end
  end

  // Stage registers: cleared by reset, hold on stall, and all advance
  // together on enable. A bubble (in_valid=0) enters stage 0 with vld=0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the stage arrays are cleared on reset, not left uninitialised,
      // so that no partial result and no stale SUM/CO is seen after reset.
      for (int k = 0; k < STAGES; k++) begin
        vld_q[k]  <= 1'b0;
        cy_q[k]   <= 1'b0;
        sub_q[k]  <= 1'b0;
        word_q[k] <= '0;
        opb_q[k]  <= '0;
      end
    end else if (en) begin
      // NOTE: non-blocking assignments let every stage sample the values
      // its predecessor held before this edge, whatever the loop order.
      for (int k = 0; k < STAGES; k++) begin
        vld_q[k]  <= vld_in[k];
        cy_q[k]   <= chunk_sum[k][CW];
        sub_q[k]  <= sub_in[k];
        word_q[k] <= word_nx[k];
        opb_q[k]  <= opb_in[k];
      end
    end
  end

endmodule

// File: tb/tb_pipelined_unsigned_adder.sv
// tb_pipelined_unsigned_adder
//
// Seven adders are built here: the 32/4 reference configuration and the
// 8-bit and 64-bit configurations with 1, 2 and 8 stages. All of them get
// the same stimulus, cut to their own width. For each configuration a
// (WIDTH+1)-bit arithmetic reference feeds a delay line of whole results,
// STAGES long, that moves only on the handshake enable. One compare process
// checks every configuration against that model on every cycle. Literal
// expectations, worked out by hand for the 32/4 configuration, check the
// model as well.

module tb_pipelined_unsigned_adder;

  localparam int NCFG = 7;

  function automatic int cfg_w(input int i);
    case (i)
      0:       return 32;
      1, 2, 3: return 8;
      default: return 64;
    endcase
  endfunction

  function automatic int cfg_s(input int i);
    case (i)
      0:       return 4;
      1, 4:    return 1;
      2, 5:    return 2;
      default: return 8;
    endcase
  endfunction

  typedef struct {
    string       name;
    int          kind;      // 0: state of cfg0 outputs, 1: bench count
    logic        valid;
    logic        ready;
    logic        chk_data;
    logic [63:0] sum;
    logic        co;
    int          got;
    int          want;
  } pin_t;

  typedef struct {
    string       name;
    logic [63:0] sum;
    logic        co;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic        sub;
  logic        ci;
  logic [63:0] a_drv;
  logic [63:0] b_drv;

  logic [NCFG-1:0] act_ready, act_valid, act_co;
  logic [NCFG-1:0] exp_ready, exp_valid, exp_co;
  logic [63:0]     act_sum [NCFG];
  logic [63:0]     exp_sum [NCFG];

  int   n_checks = 0;
  int   n_fail   = 0;
  bit   started  = 1'b0;
  bit   acc;
  int   sent;

  pin_t now_q [$];
  res_t res_q [$];

  always #5 clk = ~clk;

  generate
    for (genvar gi = 0; gi < NCFG; gi++) begin : g_cfg
      localparam int W = cfg_w(gi);
      localparam int S = cfg_s(gi);

      logic [W-1:0] dut_sum;
      logic         dut_ready, dut_valid, dut_co;

      pipelined_unsigned_adder #(.WIDTH(W), .STAGES(S)) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (dut_ready),
        .a        (a_drv[W-1:0]),
        .b        (b_drv[W-1:0]),
        .sub      (sub),
        .ci       (ci),
        .out_valid(dut_valid),
        .out_ready(out_ready),
        .sum      (dut_sum),
        .co       (dut_co)
      );

      // Exact arithmetic at WIDTH+1 bits.
      logic [W:0] ref_full;
      logic       ref_co;
      assign ref_full = sub ? ({1'b0, a_drv[W-1:0]} - {1'b0, b_drv[W-1:0]} - (W+1)'(ci))
                            : ({1'b0, a_drv[W-1:0]} + {1'b0, b_drv[W-1:0]} + (W+1)'(ci));
      assign ref_co   = sub ? (({1'b0, b_drv[W-1:0]} + (W+1)'(ci)) > {1'b0, a_drv[W-1:0]})
                            : ref_full[W];

      // Delay line of whole results, STAGES long, advanced by the handshake.
      logic         m_valid [S];
      logic [W-1:0] m_sum   [S];
      logic         m_co    [S];
      logic         m_en;
      assign m_en = out_ready | ~m_valid[S-1];

      always @(posedge clk) begin
        if (!rst_n) begin
          for (int k = 0; k < S; k++) begin
            m_valid[k] <= 1'b0;
            m_sum[k]   <= '0;
            m_co[k]    <= 1'b0;
          end
        end else if (m_en) begin
          m_valid[0] <= in_valid;
          m_sum[0]   <= ref_full[W-1:0];
          m_co[0]    <= ref_co;
          for (int k = 1; k < S; k++) begin
            m_valid[k] <= m_valid[k-1];
            m_sum[k]   <= m_sum[k-1];
            m_co[k]    <= m_co[k-1];
          end
        end
      end

      assign act_ready[gi] = dut_ready;
      assign act_valid[gi] = dut_valid;
      assign act_co[gi]    = dut_co;
      assign act_sum[gi]   = 64'(dut_sum);
      assign exp_ready[gi] = m_en;
      assign exp_valid[gi] = m_valid[S-1];
      assign exp_co[gi]    = m_co[S-1];
      assign exp_sum[gi]   = 64'(m_sum[S-1]);
    end
  endgenerate

  task automatic check(input string name, input int idx, input logic [63:0] got,
                       input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s [cfg%0d]: got %0h, expected %0h", name, idx, got, want);
    end
  endtask

  // Single compare process: the model on every cycle for every
  // configuration, then the literal results and pins for cfg0.
  always @(negedge clk) begin
    res_t r;
    pin_t p;
    if (started) begin
      for (int i = 0; i < NCFG; i++) begin
        check("in_ready", i, 64'(act_ready[i]), 64'(exp_ready[i]));
        check("out_valid", i, 64'(act_valid[i]), 64'(exp_valid[i]));
        if (exp_valid[i]) begin
          check("sum", i, act_sum[i], exp_sum[i]);
          check("co", i, 64'(act_co[i]), 64'(exp_co[i]));
        end
      end
      if (act_valid[0] && out_ready && res_q.size() > 0) begin
        r = res_q.pop_front();
        check({r.name, "_sum"}, 0, act_sum[0], r.sum);
        check({r.name, "_co"}, 0, 64'(act_co[0]), 64'(r.co));
      end
      while (now_q.size() > 0) begin
        p = now_q.pop_front();
        if (p.kind == 0) begin
          check({p.name, "_valid"}, 0, 64'(act_valid[0]), 64'(p.valid));
          check({p.name, "_ready"}, 0, 64'(act_ready[0]), 64'(p.ready));
          if (p.chk_data) begin
            check({p.name, "_sum"}, 0, act_sum[0], p.sum);
            check({p.name, "_co"}, 0, 64'(act_co[0]), 64'(p.co));
          end
        end else begin
          check(p.name, 0, 64'(p.got), 64'(p.want));
        end
      end
    end
  end

  // ---------------------------------------------------------------- helpers
  task automatic cyc();
    @(negedge clk);
    acc = in_valid && exp_ready[0];
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [63:0] av, input logic [63:0] bv,
                       input logic sv, input logic cv);
    in_valid = 1'b1;
    a_drv    = av;
    b_drv    = bv;
    sub      = sv;
    ci       = cv;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    a_drv    = {$urandom, $urandom};
    b_drv    = {$urandom, $urandom};
    sub      = 1'($urandom_range(0, 1));
    ci       = 1'($urandom_range(0, 1));
  endtask

  task automatic pin_state(input string name, input logic v, input logic r,
                           input logic chk, input logic [63:0] s, input logic c);
    pin_t p;
    p.name = name; p.kind = 0; p.valid = v; p.ready = r; p.chk_data = chk;
    p.sum = s; p.co = c; p.got = 0; p.want = 0;
    now_q.push_back(p);
  endtask

  task automatic pin_count(input string name, input int got, input int want);
    pin_t p;
    p.name = name; p.kind = 1; p.valid = 1'b0; p.ready = 1'b0; p.chk_data = 1'b0;
    p.sum = '0; p.co = 1'b0; p.got = got; p.want = want;
    now_q.push_back(p);
  endtask

  // Drive one operation until cfg0 accepts it, then queue its literal result.
  task automatic send_lit(input string name, input logic [63:0] av, input logic [63:0] bv,
                          input logic sv, input logic cv, input logic [63:0] s, input logic c);
    res_t r;
    int   tries = 0;
    drive(av, bv, sv, cv);
    cyc();
    while (!acc && tries < 20) begin
      cyc();
      tries++;
    end
    if (!acc) pin_count({name, "_accept_timeout"}, 0, 1);
    r.name = name; r.sum = s; r.co = c;
    res_q.push_back(r);
  endtask

  function automatic logic [63:0] rnd64();
    case ($urandom_range(0, 7))
      0:       return '1;
      1:       return '0;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // --------------------------------------------------------------- stimulus
  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    sub = 1'b0; ci = 1'b0; a_drv = '0; b_drv = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n   = 1'b1;
    started = 1'b1;
    pin_state("reset_state", 1'b0, 1'b1, 1'b1, 64'h0, 1'b0);

    // Back-to-back stream: exact latency of STAGES register stages.
    drive(64'h0000_FFFF, 64'h1, 1'b0, 1'b0);
    cyc();
    drive(64'hFFFF_FFFF, 64'h1, 1'b0, 1'b0);
    cyc();
    idle();
    pin_state("stream_early1", 1'b0, 1'b1, 1'b0, 64'h0, 1'b0);
    cyc();
    pin_state("stream_early2", 1'b0, 1'b1, 1'b0, 64'h0, 1'b0);
    cyc();
    pin_state("stream_res1", 1'b1, 1'b1, 1'b1, 64'h0001_0000, 1'b0);
    cyc();
    pin_state("stream_res2", 1'b1, 1'b1, 1'b1, 64'h0000_0000, 1'b1);
    cyc();
    pin_state("stream_after", 1'b0, 1'b1, 1'b0, 64'h0, 1'b0);
    cyc();

    // Subtract cases and boundary vectors, back-to-back.
    send_lit("sub_5_7",      64'h0000_0005, 64'h0000_0007, 1'b1, 1'b0, 64'hFFFF_FFFE, 1'b1);
    send_lit("sub_10_0f_b",  64'h0000_0010, 64'h0000_000F, 1'b1, 1'b1, 64'h0000_0000, 1'b0);
    send_lit("ones_ones_c",  64'hFFFF_FFFF, 64'hFFFF_FFFF, 1'b0, 1'b1, 64'hFFFF_FFFF, 1'b1);
    send_lit("zero_zero_b",  64'h0000_0000, 64'h0000_0000, 1'b1, 1'b1, 64'hFFFF_FFFF, 1'b1);
    send_lit("mixed_add",    64'h1234_5678, 64'h9ABC_DEF0, 1'b0, 1'b0, 64'hACF1_3568, 1'b0);
    send_lit("msb_add_c",    64'h8000_0000, 64'h8000_0000, 1'b0, 1'b1, 64'h0000_0001, 1'b1);
    send_lit("sub_7fff_ffff",64'h7FFF_FFFF, 64'hFFFF_FFFF, 1'b1, 1'b0, 64'h8000_0000, 1'b1);
    idle();
    repeat (8) cyc();
    pin_count("table_drained", res_q.size(), 0);

    // Backpressure: 6 operations, out_ready low for cycles 3..10.
    sent = 0;
    for (int c = 0; c < 100 && (sent < 6 || c <= 10); c++) begin
      out_ready = !(c >= 3 && c <= 10);
      if (sent < 6) drive(64'(sent * 32'h1000_0000 + 32'h0FFF_FFFF), 64'h1, 1'b0, 1'b0);
      else          idle();
      if (c == 8) pin_state("stall_hold", 1'b1, 1'b0, 1'b1, 64'h1000_0000, 1'b0);
      cyc();
      if (acc) begin
        res_t r;
        r.name = $sformatf("bp_op%0d", sent);
        r.sum  = 64'((sent + 1) * 32'h1000_0000);
        r.co   = 1'b0;
        res_q.push_back(r);
        sent++;
      end
    end
    pin_count("bp_accepted", sent, 6);
    out_ready = 1'b1;
    idle();
    repeat (8) cyc();
    pin_count("bp_drained", res_q.size(), 0);

    // Bubbles: valid operations separated by garbage cycles.
    for (int k = 0; k < 6; k++) begin
      send_lit($sformatf("bubble_op%0d", k), 64'(32'hFFFF_0000 + k), 64'h0001_0000,
               1'b0, 1'(k % 2), 64'(k + (k % 2)), 1'b1);
      idle();
      cyc();
    end
    repeat (8) cyc();
    pin_count("bubble_drained", res_q.size(), 0);

    // Reset with three operations in flight: none of them may appear.
    drive(64'h1111_1111, 64'h2222_2222, 1'b0, 1'b0);
    cyc();
    drive(64'h3333_3333, 64'h4444_4444, 1'b0, 1'b1);
    cyc();
    drive(64'h5555_5555, 64'h0000_0001, 1'b1, 1'b0);
    cyc();
    rst_n = 1'b0;
    drive(64'hDEAD_BEEF, 64'hCAFE_F00D, 1'b0, 1'b1);
    cyc();
    rst_n = 1'b1;
    idle();
    pin_state("post_reset", 1'b0, 1'b1, 1'b1, 64'h0, 1'b0);
    for (int k = 0; k < 6; k++) begin
      cyc();
      pin_state("post_reset_quiet", 1'b0, 1'b1, 1'b0, 64'h0, 1'b0);
    end
    cyc();

    // Random traffic with random handshakes on both sides.
    sent = 0;
    for (int c = 0; c < 40000 && sent < 10000; c++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) != 0)
        drive(rnd64(), rnd64(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      else
        idle();
      cyc();
      if (acc) sent++;
    end
    pin_count("random_ops", sent, 10000);

    out_ready = 1'b1;
    idle();
    repeat (12) cyc();
    pin_count("final_literal_queue", res_q.size(), 0);
    repeat (2) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "watchdog");
  end

endmodule
